// File: rtl/dmem_be_if.sv
// -----------------------------------------------------------------------------
// dmem_be_if
// Request/response bundle between the MEM pipeline stage and the byte-enabled
// data memory (dmem_be).
//
// Signals:
//   req    master->slave  access request, taken only while ready=1
//   we     master->slave  1=store, 0=load
//   size   master->slave  00=byte, 01=half, 10=word, 11=reserved
//   sext   master->slave  load sign-extend (1) / zero-extend (0)
//   addr   master->slave  byte address, little-endian
//   wdata  master->slave  right-aligned store data
//   ready  slave->master  request can be accepted this cycle
//   rvalid slave->master  load result valid
//   rdata  slave->master  extended load data
//   err    slave->master  rejected access pulse
// -----------------------------------------------------------------------------
interface dmem_be_if;
    logic        req;
    logic        we;
    logic [1:0]  size;
    logic        sext;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ready;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;

    modport master (
        output req, we, size, sext, addr, wdata,
        input  ready, rvalid, rdata, err
    );

    modport slave (
        input  req, we, size, sext, addr, wdata,
        output ready, rvalid, rdata, err
    );
endinterface

// File: rtl/dmem_be.sv
// -----------------------------------------------------------------------------
// dmem_be
// Single-port data memory for the MIPS core with byte/half/word access,
// sign/zero extension on loads, reject detection (misaligned, out of range,
// reserved size) and a sequential clear engine that writes INIT_VAL to every
// word after reset before the memory reports ready.
//
// Parameters:
//   DEPTH     number of 32-bit words (>= 2, any value)
//   INIT_VAL  value written to every word by the clear engine
//
// Ports:
//   clk   clock
//   rst   synchronous active-high reset
//   bus   dmem_be_if.slave (req/we/size/sext/addr/wdata in,
//                           ready/rvalid/rdata/err out)
//
// Build option:
//   DMEM_ASYNC_READ_EN  defined: loads, rvalid and err are combinational in
//                       the request cycle. Undefined (default): registered
//                       outputs, load data one cycle after the request.
// -----------------------------------------------------------------------------
module dmem_be #(
    parameter int          DEPTH    = 64,
    parameter logic [31:0] INIT_VAL = 32'hFFFF_FFFF
) (
    input  logic      clk,
    input  logic      rst,
    dmem_be_if.slave  bus
);

    localparam int IDX_W = (DEPTH > 2) ? $clog2(DEPTH) : 1;

    typedef enum logic {
        CLEAR,
        IDLE
    } state_t;

    state_t           state_reg;
    logic [IDX_W-1:0] cnt_reg;
    logic             ready_reg;

    // -------------------------------------------------------------------------
    // Request decode
    // -------------------------------------------------------------------------
    logic [29:0]      word_idx;
    logic             in_range;
    logic             misaligned;
    logic             reject;
    logic             acc;
    logic             st_ok;
    logic             ld_ok;
    logic [IDX_W-1:0] req_idx;

    assign word_idx = bus.addr[31:2];
    assign in_range = (word_idx < 30'(DEPTH));
    assign req_idx  = bus.addr[2 +: IDX_W];

    always_comb begin
        misaligned = 1'b0;
        case (bus.size)
            2'b01:   misaligned = bus.addr[0];
            2'b10:   misaligned = |bus.addr[1:0];
            default: misaligned = 1'b0;
        endcase
    end

    assign reject = !in_range || (bus.size == 2'b11) || misaligned;
    // rst gating keeps a request in the reset cycle from touching the array
    assign acc    = bus.req && ready_reg && !rst;
    assign st_ok  = acc && bus.we && !reject;
    assign ld_ok  = acc && !bus.we && !reject;

    assign bus.ready = ready_reg;

    // -------------------------------------------------------------------------
    // Store lane enables; data is replicated so each lane picks its own byte
    // -------------------------------------------------------------------------
    logic [3:0]  st_be;
    logic [31:0] st_data;

    always_comb begin
        st_be   = 4'b0000;
        st_data = bus.wdata;
        case (bus.size)
            2'b00: begin
                st_be   = 4'b0001 << bus.addr[1:0];
                st_data = {4{bus.wdata[7:0]}};
            end
            2'b01: begin
                st_be   = bus.addr[1] ? 4'b1100 : 4'b0011;
                st_data = {2{bus.wdata[15:0]}};
            end
            2'b10: begin
                st_be   = 4'b1111;
                st_data = bus.wdata;
            end
            default: begin
                st_be   = 4'b0000;
                st_data = bus.wdata;
            end
        endcase
    end

    // Single write port shared by the clear engine and stores; they never
    // overlap because stores need ready=1, which only exists in IDLE.
    logic             clearing;
    logic [IDX_W-1:0] wr_idx;
    logic [3:0]       wr_be;
    logic [31:0]      wr_data;

    assign clearing = (state_reg == CLEAR) && !rst;
    assign wr_idx   = clearing ? cnt_reg : req_idx;
    assign wr_be    = clearing ? 4'b1111 : (st_ok ? st_be : 4'b0000);
    assign wr_data  = clearing ? INIT_VAL : st_data;

    // -------------------------------------------------------------------------
    // Load extraction / extension
    // -------------------------------------------------------------------------
    function automatic logic [31:0] load_extend(
        input logic [31:0] w,
        input logic [1:0]  off,
        input logic [1:0]  sz,
        input logic        sx
    );
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            2'b00:   b = w[7:0];
            2'b01:   b = w[15:8];
            2'b10:   b = w[23:16];
            default: b = w[31:24];
        endcase
        h = off[1] ? w[31:16] : w[15:0];
        case (sz)
            2'b00:   load_extend = {{24{sx & b[7]}}, b};
            2'b01:   load_extend = {{16{sx & h[15]}}, h};
            default: load_extend = w;
        endcase
    endfunction

    // -------------------------------------------------------------------------
    // Memory: one byte-wide array per lane so each infers a simple RAM with
    // its own write enable.
    // -------------------------------------------------------------------------
    logic [31:0] rd_word;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] mem [DEPTH];

            always_ff @(posedge clk) begin
                if (wr_be[gi]) begin
                    mem[wr_idx] <= wr_data[gi*8 +: 8];
                end
            end

`ifdef DMEM_ASYNC_READ_EN
            assign rd_word[gi*8 +: 8] = mem[req_idx];
`else
            logic [7:0] q_reg;

            // Only accepted in-range loads read, so the output register
            // holds the previous load when idle.
            always_ff @(posedge clk) begin
                if (ld_ok) begin
                    q_reg <= mem[req_idx];
                end
            end

            assign rd_word[gi*8 +: 8] = q_reg;
`endif
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Control FSM: clear engine then IDLE
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= CLEAR;
            cnt_reg   <= '0;
            ready_reg <= 1'b0;
        end else begin
            case (state_reg)
                CLEAR: begin
                    if (cnt_reg == IDX_W'(DEPTH - 1)) begin
                        state_reg <= IDLE;
                        ready_reg <= 1'b1;
                        cnt_reg   <= '0;
                    end else begin
                        cnt_reg   <= cnt_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    ready_reg <= 1'b1;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Response path
    // -------------------------------------------------------------------------
`ifdef DMEM_ASYNC_READ_EN
    assign bus.rvalid = acc && !bus.we;
    assign bus.err    = acc && reject;
    assign bus.rdata  = reject ? 32'h0
                               : load_extend(rd_word, bus.addr[1:0], bus.size, bus.sext);
`else
    logic       rvalid_reg;
    logic       err_reg;
    logic       rd_zero_reg;
    logic [1:0] rd_off_reg;
    logic [1:0] rd_size_reg;
    logic       rd_sext_reg;

    // The raw lane registers are extended after the RAM read; rd_zero_reg
    // forces 0 for reset and for rejected loads without resetting the RAM.
    always_ff @(posedge clk) begin
        if (rst) begin
            rvalid_reg  <= 1'b0;
            err_reg     <= 1'b0;
            rd_zero_reg <= 1'b1;
            rd_off_reg  <= 2'b00;
            rd_size_reg <= 2'b10;
            rd_sext_reg <= 1'b0;
        end else begin
            rvalid_reg <= acc && !bus.we;
            err_reg    <= acc && reject;
            if (acc && !bus.we) begin
                rd_zero_reg <= reject;
                rd_off_reg  <= bus.addr[1:0];
                rd_size_reg <= bus.size;
                rd_sext_reg <= bus.sext;
            end
        end
    end

    assign bus.rvalid = rvalid_reg;
    assign bus.err    = err_reg;
    assign bus.rdata  = rd_zero_reg ? 32'h0
                                    : load_extend(rd_word, rd_off_reg, rd_size_reg, rd_sext_reg);
`endif

endmodule

// File: tb/tb_dmem_be.sv
// -----------------------------------------------------------------------------
// tb_dmem_be
// Directed bench for dmem_be (DEPTH=16, registered-read build). The stimulus
// process pushes expected responses into a scoreboard queue; a monitor on the
// falling edge pops and compares whenever rvalid or err is seen, including the
// cycle on which the response arrives.
// -----------------------------------------------------------------------------
module tb_dmem_be;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    dmem_be_if bus();

    dmem_be #(
        .DEPTH    (16),
        .INIT_VAL (32'hFFFF_FFFF)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic        rvalid;
        logic        err;
        logic        chk_rdata;
        logic [31:0] rdata;
        int          due;
        string       name;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   passes = 0;
    int   cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Drive one request for one cycle; expected response (if any) is queued.
    task automatic issue(input string name, input logic w, input logic [1:0] sz,
                         input logic sx, input logic [31:0] a, input logic [31:0] d,
                         input logic ev, input logic ee, input logic [31:0] er);
        exp_t e;
        bus.req   = 1'b1;
        bus.we    = w;
        bus.size  = sz;
        bus.sext  = sx;
        bus.addr  = a;
        bus.wdata = d;
        if (ev || ee) begin
            e.rvalid    = ev;
            e.err       = ee;
            e.chk_rdata = ev;
            e.rdata     = er;
            e.due       = cyc + 1;
            e.name      = name;
            sb_q.push_back(e);
        end
        @(posedge clk);
        #1;
        bus.req = 1'b0;
    endtask

    // Count cycles until ready rises (bounded).
    task automatic wait_ready(input string name, input int exp_n);
        int n = 0;
        while (bus.ready !== 1'b1 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        bus.req = 1'b0;
        check(name, 32'(n), 32'(exp_n));
    endtask

    // Monitor
    exp_t m;
    always @(negedge clk) begin
        if (!rst && (bus.rvalid === 1'b1 || bus.err === 1'b1)) begin
            if (sb_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_output: rvalid=%b err=%b rdata=%h expected no output",
                         bus.rvalid, bus.err, bus.rdata);
            end else begin
                m = sb_q.pop_front();
                $display("txn %s: rvalid=%b err=%b rdata=%h cycle=%0d",
                         m.name, bus.rvalid, bus.err, bus.rdata, cyc);
                check({m.name, "_rvalid"}, {31'b0, bus.rvalid}, {31'b0, m.rvalid});
                check({m.name, "_err"},    {31'b0, bus.err},    {31'b0, m.err});
                if (m.chk_rdata) check({m.name, "_rdata"}, bus.rdata, m.rdata);
                check({m.name, "_latency"}, 32'(cyc), 32'(m.due));
            end
        end
    end

    initial begin
        int n;
        bus.req   = 1'b0;
        bus.we    = 1'b0;
        bus.size  = 2'b10;
        bus.sext  = 1'b0;
        bus.addr  = 32'h0;
        bus.wdata = 32'h0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready",  {31'b0, bus.ready},  32'h0);
        check("rst_rvalid", {31'b0, bus.rvalid}, 32'h0);
        check("rst_err",    {31'b0, bus.err},    32'h0);
        check("rst_rdata",  bus.rdata,           32'h0);
        rst = 1'b0;
        wait_ready("clear1_cycles", 16);

        // 1: boundary word and first out-of-range word
        issue("lw_3c", 1'b0, 2'b10, 1'b0, 32'h3C, 32'h0, 1'b1, 1'b0, 32'hFFFF_FFFF);
        issue("lw_40", 1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 1'b1, 1'b1, 32'h0);

        // 2: sub-word stores and loads
        issue("sw_8",   1'b1, 2'b10, 1'b0, 32'h8, 32'h1122_3344, 1'b0, 1'b0, 32'h0);
        issue("sb_9",   1'b1, 2'b00, 1'b0, 32'h9, 32'h0000_00AA, 1'b0, 1'b0, 32'h0);
        issue("lw_8",   1'b0, 2'b10, 1'b0, 32'h8, 32'h0, 1'b1, 1'b0, 32'h1122_AA44);
        issue("lb_9",   1'b0, 2'b00, 1'b1, 32'h9, 32'h0, 1'b1, 1'b0, 32'hFFFF_FFAA);
        issue("lbu_9",  1'b0, 2'b00, 1'b0, 32'h9, 32'h0, 1'b1, 1'b0, 32'h0000_00AA);
        issue("lh_a",   1'b0, 2'b01, 1'b1, 32'hA, 32'h0, 1'b1, 1'b0, 32'h0000_1122);

        // 3: halfword in upper lanes
        issue("sh_2",   1'b1, 2'b01, 1'b0, 32'h2, 32'h0000_8001, 1'b0, 1'b0, 32'h0);
        issue("lh_2",   1'b0, 2'b01, 1'b1, 32'h2, 32'h0, 1'b1, 1'b0, 32'hFFFF_8001);
        issue("lhu_2",  1'b0, 2'b01, 1'b0, 32'h2, 32'h0, 1'b1, 1'b0, 32'h0000_8001);
        issue("lw_0",   1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h8001_FFFF);

        // 4: rejects
        issue("lw_6_mis",  1'b0, 2'b10, 1'b0, 32'h6, 32'h0, 1'b1, 1'b1, 32'h0);
        issue("sh_5_mis",  1'b1, 2'b01, 1'b0, 32'h5, 32'h1234, 1'b0, 1'b1, 32'h0);
        issue("lw_4",      1'b0, 2'b10, 1'b0, 32'h4, 32'h0, 1'b1, 1'b0, 32'hFFFF_FFFF);
        issue("ld_rsv",    1'b0, 2'b11, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h0);
        issue("st_rsv",    1'b1, 2'b11, 1'b0, 32'h4, 32'h0, 1'b0, 1'b1, 32'h0);
        issue("lw_4_again",1'b0, 2'b10, 1'b0, 32'h4, 32'h0, 1'b1, 1'b0, 32'hFFFF_FFFF);

        // 5: store then immediate load of same address, then rdata hold
        issue("sw_10",  1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0);
        issue("lw_10",  1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 32'hDEAD_BEEF);
        issue("sw_14",  1'b1, 2'b10, 1'b0, 32'h14, 32'h0BAD_F00D, 1'b0, 1'b0, 32'h0);
        check("rdata_hold", bus.rdata, 32'hDEAD_BEEF);

        // 6: clear restart, with a load held during clear
        issue("sw_0_zero", 1'b1, 2'b10, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        issue("lw_0_zero", 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.req  = 1'b1;
        bus.we   = 1'b0;
        bus.size = 2'b10;
        bus.addr = 32'h0;
        wait_ready("clear2_cycles", 16);
        issue("lw_0_cleared", 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'hFFFF_FFFF);

        // Drain
        n = 0;
        while (sb_q.size() != 0 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("sb_drained", 32'(sb_q.size()), 32'h0);
        repeat (3) @(posedge clk);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/dmem_be.md
Name: dmem_be

Overview:
Parametrised single-port data memory for the MIPS core with byte-addressed sub-word access. Supports word, halfword and byte loads and stores, with sign or zero extension on loads. Uses a request/valid handshake with one-cycle registered read latency. Flags misaligned and out-of-range accesses. A sequential clear engine initialises every word after reset. Sits between the MEM pipeline stage and the memory array, replacing the fixed 64-word, word-only dmem.

Parameters:
DEPTH, 64, number of 32-bit words (need not be a power of 2; minimum 2)
INIT_VAL, 32'hFFFFFFFF, value written to every word by the clear engine

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
req  input  1  access request; accepted only when ready=1
we  input  1  1=store, 0=load (sampled with req)
size  input  2  00=byte, 01=half, 10=word, 11=reserved
sext  input  1  load sign-extend (1) / zero-extend (0); ignored for word and stores
addr  input  32  byte address, little-endian (lane 0 = bits 7:0)
wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0])
ready  output  1  block can accept a request this cycle
rvalid  output  1  load result valid (one-cycle pulse)
rdata  output  32  extended load data
err  output  1  one-cycle pulse: rejected access (misaligned, out of range or reserved size)

Behaviour:
- Clock clk; reset rst is synchronous, active-high.
- States: CLEAR, IDLE.
- Reset: rst sampled high -> state=CLEAR, clear counter=0, ready=0, rvalid=0, err=0, rdata=0. All outputs hold these values while rst is high.
- CLEAR: each cycle with rst low, write INIT_VAL to word[counter], then counter++. After the write to word DEPTH-1, go to IDLE. ready=1 from the next cycle. Clear therefore takes exactly DEPTH cycles after rst deasserts.
- rst asserted mid-CLEAR restarts the counter at 0. No partial-clear state survives.
- req while ready=0 is dropped: no write, no rvalid, no err.
- Word index = addr[31:2]. An access is rejected if any of the following hold:
  - index >= DEPTH
  - size=11
  - size=01 with addr[0]=1
  - size=10 with addr[1:0]!=0
- Rejected access: no memory change; err=1 on the next cycle. For a rejected load, rvalid=1 with rdata=0 on that same cycle.
- Store (accepted in cycle N): memory updated at the clk edge ending cycle N.
  - byte: lane addr[1:0] only
  - half: lanes {addr[1],0} and {addr[1],1}
  - word: all 4 lanes
  - Other lanes are unchanged. No rvalid.
- Load (accepted in cycle N): rvalid=1 and rdata valid in cycle N+1.
  - Lane select as for stores.
  - byte/half results are extended to 32 bits per sext.
- Back-to-back requests are accepted every cycle in IDLE. A load in cycle N+1 to the address stored in cycle N returns the new data.
- rvalid, err and rdata are registered. rdata holds its last value when rvalid=0.
- Array contents are not reset by the rst edge itself, only by the clear engine.

Optional Feature:
DMEM_ASYNC_READ_EN:
- Defined: loads are combinational. rdata and rvalid (=req&ready&~we) are valid in the same cycle as the request, and err is combinational for rejected accesses. This matches the single-cycle core timing.
- Not defined: registered one-cycle latency as specified above.
- Clear engine, stores and reject rules are identical in both builds.

Test Plan:
1. DEPTH=16, pulse rst 2 cycles -> ready=0 for exactly 16 cycles after rst falls, then 1. lw 0x3C -> rdata 0xFFFFFFFF. lw 0x40 -> err=1, rvalid=1, rdata 0.
2. sw 0x11223344 @0x8; sb 0xAA @0x9; lw @0x8 -> 0x1122AA44. lb sext=1 @0x9 -> 0xFFFFFFAA. lbu @0x9 -> 0x000000AA. lh sext=1 @0xA -> 0x00001122.
3. sh 0x8001 @0x2, then lh sext=1 @0x2 -> 0xFFFF8001. lhu @0x2 -> 0x00008001. lw @0x0 -> 0x8001FFFF.
4. Misaligned: lw @0x6 -> err, rdata 0. sh 0x1234 @0x5 -> err, then lw @0x4 -> 0xFFFFFFFF (unchanged). size=11 -> err.
5. sw 0xDEADBEEF @0x10 in cycle N, lw @0x10 in cycle N+1 -> rvalid in N+2 with 0xDEADBEEF. req held while ready=0 during clear -> no rvalid, no err.
6. Write 0x0 @0x0, then assert rst after 5 clear cycles -> clear restarts. ready rises 16 cycles after the final rst deassert, and lw @0x0 -> 0xFFFFFFFF.
